// File: rtl/bus_responder_6502.sv
// Bridges a 6502-style PHI_2 bus onto a synchronous RAM port, inserting read wait
// states, and raises sticky STOP / TRAP / TIMEOUT flags for simulation harnesses.
module bus_responder_6502 #(
  parameter logic [15:0] STOP_ADR    = 16'hFFFC,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIME_LIMIT  = 100000
) (
  input  logic        clk,
  input  logic        RES,
  input  logic [15:0] Address_bus,
  input  logic [7:0]  Data_in,
  input  logic        RnW,
  input  logic        PHI_2,
  input  logic        SYNC,
  output logic [7:0]  Data_out,
  output logic        READY,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        STOP,
  output logic        TRAP,
  output logic        TIMEOUT,
  output logic [15:0] trap_pc
);

  typedef enum logic [2:0] {StIdle, StRdIssue, StRdWait, StRdDone, StWrHold} state_e;

  state_e      state_q, state_d;
  logic        phi2_q;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] last_sync_q, last_sync_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        ready_q, ready_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        stop_q, stop_d;
  logic        trap_q, trap_d;
  logic        timeout_q, timeout_d;
  logic [15:0] trap_pc_q, trap_pc_d;

  logic bus_start, bus_end;
  assign bus_start = PHI_2 & ~phi2_q;
  assign bus_end   = ~PHI_2 & phi2_q;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    last_sync_d = last_sync_q;
    cyc_cnt_d   = cyc_cnt_q;
    data_out_d  = data_out_q;
    ready_d     = ready_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    stop_d      = stop_q;
    trap_d      = trap_q;
    timeout_d   = timeout_q;
    trap_pc_d   = trap_pc_q;

    unique case (state_q)
      StIdle: ;
      StRdIssue: begin
        wait_d  = 4'(WAIT_STATES);
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wait_q == 4'd0) begin
          data_out_d = mem_rdata;
          ready_d    = 1'b1;
          state_d    = StRdDone;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      StRdDone: if (bus_end) state_d = StIdle;
      StWrHold: begin
        if (PHI_2) begin
          wr_addr_d = Address_bus;
          wr_data_d = Data_in;
        end
        // The write commits only once the CPU has finished driving the bus.
        if (bus_end) begin
          if (wr_addr_q == STOP_ADR) begin
            stop_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = wr_data_q;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new bus cycle always wins, aborting whatever transfer was in flight.
    if (bus_start) begin
      if (RnW) begin
        mem_addr_d = Address_bus;
        ready_d    = 1'b0;
        state_d    = StRdIssue;
      end else begin
        wr_addr_d = Address_bus;
        wr_data_d = Data_in;
        ready_d   = 1'b1;
        state_d   = StWrHold;
      end

      if (SYNC) begin
        if (Address_bus == last_sync_q) begin
          trap_d = 1'b1;
          if (!trap_q) trap_pc_d = Address_bus;
        end else begin
          last_sync_d = Address_bus;
        end
      end

      if (cyc_cnt_q != 32'hFFFF_FFFF) cyc_cnt_d = cyc_cnt_q + 32'd1;
      if (cyc_cnt_d >= TIME_LIMIT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RES) begin
      state_q     <= StIdle;
      phi2_q      <= 1'b0;
      wait_q      <= 4'd0;
      wr_addr_q   <= 16'h0000;
      wr_data_q   <= 8'h00;
      last_sync_q <= 16'hFFFC;
      cyc_cnt_q   <= 32'd0;
      data_out_q  <= 8'h00;
      ready_q     <= 1'b1;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
      stop_q      <= 1'b0;
      trap_q      <= 1'b0;
      timeout_q   <= 1'b0;
      trap_pc_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      phi2_q      <= PHI_2;
      wait_q      <= wait_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      last_sync_q <= last_sync_d;
      cyc_cnt_q   <= cyc_cnt_d;
      data_out_q  <= data_out_d;
      ready_q     <= ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      stop_q      <= stop_d;
      trap_q      <= trap_d;
      timeout_q   <= timeout_d;
      trap_pc_q   <= trap_pc_d;
    end
  end

  assign Data_out  = data_out_q;
  assign READY     = ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign STOP      = stop_q;
  assign TRAP      = trap_q;
  assign TIMEOUT   = timeout_q;
  assign trap_pc   = trap_pc_q;

endmodule

// File: tb/tb_bus_responder_6502.sv
// Bench for bus_responder_6502: two instances (0 and 3 wait states) driven in parallel,
// checked every cycle against a timestamp-based bus model plus directed literal checks.
module tb_bus_responder_6502;

  localparam int unsigned Ws0 = 0;
  localparam int unsigned Ws1 = 3;
  localparam int unsigned Limit = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RES, RnW, PHI_2, SYNC;
  logic [15:0] Address_bus;
  logic [7:0]  Data_in;

  logic [7:0]  data_out0, data_out1, mem_wdata0, mem_wdata1, rdata0, rdata1;
  logic [15:0] mem_addr0, mem_addr1, trap_pc0, trap_pc1;
  logic        ready0, ready1, mem_we0, mem_we1;
  logic        stop0, stop1, trap0, trap1, timeout0, timeout1;

  bus_responder_6502 #(.WAIT_STATES(Ws0), .TIME_LIMIT(Limit)) u_dut0 (
    .clk(clk), .RES(RES), .Address_bus(Address_bus), .Data_in(Data_in), .RnW(RnW),
    .PHI_2(PHI_2), .SYNC(SYNC), .Data_out(data_out0), .READY(ready0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_we(mem_we0), .mem_rdata(rdata0), .STOP(stop0), .TRAP(trap0),
    .TIMEOUT(timeout0), .trap_pc(trap_pc0)
  );

  bus_responder_6502 #(.WAIT_STATES(Ws1), .TIME_LIMIT(Limit)) u_dut1 (
    .clk(clk), .RES(RES), .Address_bus(Address_bus), .Data_in(Data_in), .RnW(RnW),
    .PHI_2(PHI_2), .SYNC(SYNC), .Data_out(data_out1), .READY(ready1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(rdata1), .STOP(stop1), .TRAP(trap1),
    .TIMEOUT(timeout1), .trap_pc(trap_pc1)
  );

  // Memory contents are a fixed function of address; writes are checked on the port itself.
  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h1234) return 8'hA5;
    if (a == 16'h00FF) return 8'h3C;
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) rdata0 <= pat(mem_addr0);
  always @(posedge clk) rdata1 <= pat(mem_addr1);

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected outputs after each clock edge, derived from bus events and timestamps.
  int unsigned n = 0;
  logic        m_phi;
  logic [7:0]  m_dout [2];
  logic        m_ready [2];
  logic        rd_pend [2];
  int unsigned rd_due [2];
  logic [15:0] rd_addr, wr_a, m_maddr, m_trap_pc, m_last_sync;
  logic [7:0]  wr_d, m_wdata;
  logic        wr_pend, m_we, m_stop, m_trap, m_timeout;
  int unsigned m_starts;

  task automatic model_step();
    logic bstart, bend;
    n++;
    if (RES) begin
      m_phi = 1'b0; wr_pend = 1'b0; m_we = 1'b0; m_maddr = 16'h0; m_wdata = 8'h0;
      m_stop = 1'b0; m_trap = 1'b0; m_timeout = 1'b0; m_trap_pc = 16'h0;
      m_last_sync = 16'hFFFC; m_starts = 0;
      for (int k = 0; k < 2; k++) begin
        m_dout[k] = 8'h00; m_ready[k] = 1'b1; rd_pend[k] = 1'b0;
      end
    end else begin
      bstart = PHI_2 && !m_phi;
      bend   = !PHI_2 && m_phi;
      m_we   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (rd_pend[k] && n == rd_due[k]) begin
          m_dout[k] = pat(rd_addr); m_ready[k] = 1'b1; rd_pend[k] = 1'b0;
        end
      end
      if (wr_pend && PHI_2) begin
        wr_a = Address_bus; wr_d = Data_in;
      end
      if (wr_pend && bend) begin
        wr_pend = 1'b0;
        if (wr_a == 16'hFFFC) m_stop = 1'b1;
        else begin
          m_we = 1'b1; m_maddr = wr_a; m_wdata = wr_d;
        end
      end
      if (bstart) begin
        m_starts++;
        if (m_starts >= Limit) m_timeout = 1'b1;
        if (SYNC) begin
          if (Address_bus == m_last_sync) begin
            if (!m_trap) m_trap_pc = Address_bus;
            m_trap = 1'b1;
          end else m_last_sync = Address_bus;
        end
        if (RnW) begin
          rd_addr = Address_bus; m_maddr = Address_bus; wr_pend = 1'b0;
          rd_pend[0] = 1'b1; rd_due[0] = n + 2 + Ws0; m_ready[0] = 1'b0;
          rd_pend[1] = 1'b1; rd_due[1] = n + 2 + Ws1; m_ready[1] = 1'b0;
        end else begin
          wr_pend = 1'b1; wr_a = Address_bus; wr_d = Data_in;
          for (int k = 0; k < 2; k++) begin
            rd_pend[k] = 1'b0; m_ready[k] = 1'b1;
          end
        end
      end
      m_phi = PHI_2;
    end
  endtask

  task automatic compare_dut(input int k, input logic [7:0] dout, input logic rdy,
                             input logic we, input logic [15:0] ma, input logic [7:0] md,
                             input logic st, input logic tr, input logic to,
                             input logic [15:0] tpc);
    check($sformatf("dut%0d Data_out", k), dout, m_dout[k]);
    check($sformatf("dut%0d READY", k), rdy, m_ready[k]);
    check($sformatf("dut%0d mem_we", k), we, m_we);
    check($sformatf("dut%0d mem_addr", k), ma, m_maddr);
    check($sformatf("dut%0d mem_wdata", k), md, m_wdata);
    check($sformatf("dut%0d STOP", k), st, m_stop);
    check($sformatf("dut%0d TRAP", k), tr, m_trap);
    check($sformatf("dut%0d TIMEOUT", k), to, m_timeout);
    check($sformatf("dut%0d trap_pc", k), tpc, m_trap_pc);
  endtask

  // Inputs change 2 time units after posedge, so at negedge they show what the next edge sees.
  initial begin
    bit chk_en = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        compare_dut(0, data_out0, ready0, mem_we0, mem_addr0, mem_wdata0, stop0, trap0,
                    timeout0, trap_pc0);
        compare_dut(1, data_out1, ready1, mem_we1, mem_addr1, mem_wdata1, stop1, trap1,
                    timeout1, trap_pc1);
      end
      model_step();
      chk_en = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    RES = 1'b1; PHI_2 = 1'b0; RnW = 1'b1; SYNC = 1'b0;
    tick(); tick();
    RES = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [15:0] a, input logic sync, output int lo0, output int lo1,
                         output logic [7:0] d0_2, output logic [7:0] d0_3,
                         output logic [7:0] d1_5, output logic [7:0] d1_6);
    Address_bus = a; RnW = 1'b1; SYNC = sync; PHI_2 = 1'b1;
    lo0 = 0; lo1 = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      SYNC = 1'b0;
      if (!ready0) lo0++;
      if (!ready1) lo1++;
      if (c == 2) d0_2 = data_out0;
      if (c == 3) d0_3 = data_out0;
      if (c == 5) d1_5 = data_out1;
      if (c == 6) d1_6 = data_out1;
    end
    PHI_2 = 1'b0;
    tick(); tick();
  endtask

  task automatic do_write(input logic [15:0] a1, input logic [7:0] v1, input logic [15:0] a2,
                          input logic [7:0] v2, output logic we_end, output logic [15:0] ma,
                          output logic [7:0] md, output logic we_after);
    Address_bus = a1; Data_in = v1; RnW = 1'b0; PHI_2 = 1'b1;
    tick(); tick();
    Address_bus = a2; Data_in = v2;
    tick();
    PHI_2 = 1'b0; RnW = 1'b1;
    tick();
    we_end = mem_we0; ma = mem_addr0; md = mem_wdata0;
    tick();
    we_after = mem_we0;
    tick();
  endtask

  initial begin
    int lo0, lo1;
    logic [7:0] d0_2, d0_3, d1_5, d1_6, md;
    logic [15:0] ma;
    logic we_end, we_after;

    RES = 1'b1; PHI_2 = 1'b0; RnW = 1'b1; SYNC = 1'b0; Address_bus = 16'h0; Data_in = 8'h0;
    tick(); tick();
    check("reset READY", ready0, 1'b1);
    check("reset Data_out", data_out1, 8'h00);
    check("reset mem_addr", mem_addr0, 16'h0000);
    check("reset trap_pc", trap_pc1, 16'h0000);
    RES = 1'b0;
    tick();

    do_read(16'h1234, 1'b0, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    check("ws0 READY low clks", lo0, 2);
    check("ws3 READY low clks", lo1, 5);
    check("ws0 Data_out at start+1", d0_2, 8'h00);
    check("ws0 Data_out at start+2", d0_3, 8'hA5);
    check("ws3 Data_out at start+4", d1_5, 8'h00);
    check("ws3 Data_out at start+5", d1_6, 8'hA5);

    do_read(16'h00FF, 1'b0, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    check("read 00FF ws0", data_out0, 8'h3C);
    check("read 00FF ws3", data_out1, 8'h3C);
    do_read(16'h0777, 1'b0, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    check("read 0777", data_out1, 8'h70);

    do_write(16'h0200, 8'h5A, 16'h0200, 8'h5A, we_end, ma, md, we_after);
    check("write mem_we pulse", we_end, 1'b1);
    check("write mem_addr", ma, 16'h0200);
    check("write mem_wdata", md, 8'h5A);
    check("write mem_we after pulse", we_after, 1'b0);
    check("Data_out held over write", data_out0, 8'h70);

    do_write(16'h0300, 8'h11, 16'h0301, 8'h22, we_end, ma, md, we_after);
    check("late capture mem_addr", ma, 16'h0301);
    check("late capture mem_wdata", md, 8'h22);

    do_write(16'hFFFC, 8'h77, 16'hFFFC, 8'h77, we_end, ma, md, we_after);
    check("stop write no mem_we", we_end, 1'b0);
    check("STOP set", stop0, 1'b1);

    do_reset();
    do_read(16'h0400, 1'b1, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    do_read(16'h0402, 1'b1, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    check("no TRAP before repeat", trap0, 1'b0);
    do_read(16'h0402, 1'b1, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    check("TRAP on repeat", trap0, 1'b1);
    check("trap_pc first", trap_pc0, 16'h0402);
    do_read(16'h0500, 1'b1, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    do_read(16'h0500, 1'b1, lo0, lo1, d0_2, d0_3, d1_5, d1_6);
    check("trap_pc kept", trap_pc1, 16'h0402);

    do_reset();
    Address_bus = 16'h0000;
    for (int i = 1; i <= 10; i++) begin
      RnW = 1'b1; PHI_2 = 1'b1;
      tick();
      check($sformatf("TIMEOUT after start %0d", i), timeout0, (i == 10));
      tick();
      PHI_2 = 1'b0;
      tick(); tick();
    end
    repeat (3) tick();
    check("TIMEOUT sticky", timeout1, 1'b1);

    // Reset while both instances sit in the read wait phase.
    do_reset();
    Address_bus = 16'h1234; RnW = 1'b1; PHI_2 = 1'b1;
    tick(); tick();
    RES = 1'b1;
    tick();
    check("RES in read READY", ready1, 1'b1);
    check("RES in read Data_out ws0", data_out0, 8'h00);
    check("RES in read mem_addr", mem_addr1, 16'h0000);
    RES = 1'b0; PHI_2 = 1'b0;
    repeat (6) tick();
    check("no read completes after RES", data_out1, 8'h00);

    // Reset while a write is held.
    Address_bus = 16'h0210; Data_in = 8'h99; RnW = 1'b0; PHI_2 = 1'b1;
    tick(); tick();
    RES = 1'b1;
    tick();
    check("RES in write mem_we", mem_we0, 1'b0);
    RES = 1'b0; PHI_2 = 1'b0; RnW = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no mem_we after write RES", mem_we1, 1'b0);
    end
    check("mem_addr after write RES", mem_addr0, 16'h0000);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_responder_6502.md
BUS_RESPONDER_6502 -- requirements
Module: bus_responder_6502

Interface
REQ-001 SHALL have parameter STOP_ADR, default 16'hFFFC: write address that raises STOP instead of writing memory.
REQ-002 SHALL have parameter WAIT_STATES, default 0: extra clk cycles READY is held low on every read (0..15).
REQ-003 SHALL have parameter TIME_LIMIT, default 100000: PHI_2 rising-edge count at which TIMEOUT asserts.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port RES, input, 1: reset; synchronous, active-high.
REQ-006 SHALL have port Address_bus, input, 16: CPU address.
REQ-007 SHALL have port Data_in, input, 8: CPU write data.
REQ-008 SHALL have ports RnW, PHI_2 and SYNC, each input, 1: CPU bus strobes.
REQ-009 SHALL have port Data_out, output, 8: read data to CPU.
REQ-010 SHALL have port READY, output, 1: CPU ready (low = stall).
REQ-011 SHALL have ports mem_addr (output, 16), mem_wdata (output, 8), mem_we (output, 1) and mem_rdata (input, 8): synchronous RAM port with 1-cycle read latency.
REQ-012 SHALL have ports STOP, TRAP and TIMEOUT, each output, 1: sticky status flags.
REQ-013 SHALL have port trap_pc, output, 16: opcode address at which TRAP fired.

Function
REQ-014 SHALL define bus-cycle start as a clk where PHI_2=1 and the registered previous PHI_2=0; bus-cycle end as a clk where PHI_2=0 and previous PHI_2=1.
REQ-015 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, RD_DONE and WR_HOLD.
REQ-016 SHALL, at start with RnW=1 in IDLE: drive mem_addr=Address_bus, mem_we=0, go to RD_ISSUE, and drive READY=0 from the next clk.
REQ-017 SHALL in RD_ISSUE load a wait counter with WAIT_STATES, then go to RD_WAIT.
REQ-018 SHALL in RD_WAIT decrement the counter to 0, then register mem_rdata into Data_out, drive READY=1 and go to RD_DONE; read latency from start to Data_out valid is 2+WAIT_STATES clk.
REQ-019 SHALL hold Data_out stable from RD_DONE until the next read completes, and return RD_DONE to IDLE at bus-cycle end.
REQ-020 SHALL, at start with RnW=0: go to WR_HOLD; on every clk in WR_HOLD with PHI_2=1, capture Address_bus and Data_in.
REQ-021 SHALL, at bus-cycle end in WR_HOLD, pulse mem_we for exactly one clk with the last captured address/data, then return to IDLE.
REQ-022 SHALL, when the captured write address equals STOP_ADR, suppress mem_we and set STOP instead.
REQ-023 SHALL keep READY=1 for all writes.
REQ-024 SHALL, at bus-cycle start with SYNC=1, compare Address_bus to a last_sync register (reset 16'hFFFC); if equal, set TRAP and load trap_pc=Address_bus; otherwise update last_sync.
REQ-025 SHALL latch trap_pc only on the first TRAP; later matches do not change it.
REQ-026 SHALL count bus-cycle starts in a 32-bit saturating counter and set TIMEOUT when the count reaches TIME_LIMIT.
REQ-027 SHALL keep STOP, TRAP and TIMEOUT sticky until RES.
REQ-028 SHALL treat a start arriving while the FSM is not IDLE (CPU ignored READY) as a new cycle: abort the current one, with no mem_we for an aborted write.
REQ-029 SHALL treat WAIT_STATES=0 as RD_WAIT occupying one clk.

Reset
REQ-030 SHALL, on RES=1 at a clk edge, set: FSM=IDLE, Data_out=8'h00, READY=1, mem_we=0, mem_addr=16'h0000, mem_wdata=8'h00, STOP=TRAP=TIMEOUT=0, trap_pc=16'h0000, last_sync=16'hFFFC, counters=0, previous PHI_2=0.
REQ-031 SHALL let RES mid-cycle abort any pending read or write, with no mem_we issued afterwards for that cycle.
REQ-032 SHALL give RES priority over every other event in the same clk.

Verification
REQ-033 SHALL cover: WAIT_STATES=0, mem[16'h1234]=8'hA5, read of 16'h1234 -> READY low 2 clk, Data_out=8'hA5 two clk after start.
REQ-034 SHALL cover: WAIT_STATES=3, same read -> READY low 5 clk, Data_out=8'hA5 at start+5.
REQ-035 SHALL cover: write 8'h5A to 16'h0200 -> single mem_we pulse one clk after PHI_2 falls, mem_addr=16'h0200, mem_wdata=8'h5A; then write to 16'hFFFC -> STOP=1 with no mem_we.
REQ-036 SHALL cover: SYNC cycles at 16'h0400, 16'h0402, 16'h0402 -> TRAP=1, trap_pc=16'h0402; then 16'h0500, 16'h0500 -> trap_pc stays 16'h0402.
REQ-037 SHALL cover: TIME_LIMIT=10, 10 PHI_2 cycles -> TIMEOUT=1 on the 10th start, and it remains set.
REQ-038 SHALL cover: RES asserted in RD_WAIT and in WR_HOLD -> all outputs at reset values the next clk, no mem_we.
